// File: rtl/summation_if.sv
// Bus between the summation block and its user: N in, registered series sum out.
interface summation_if #(
   parameter int unsigned N_WIDTH   = 4,
   parameter int unsigned SUM_WIDTH = 7
);
   logic [N_WIDTH-1:0]   N;
   logic [SUM_WIDTH-1:0] sum;

   // User side: drives N, observes sum
   modport master (
      output N,
      input  sum
   );

   // Block side: observes N, drives sum
   modport slave (
      input  N,
      output sum
   );
endinterface

// File: rtl/summation.sv
// summation: registered arithmetic series sum 1+2+...+N of the bus input N.
// Default build is an iterative accumulator (one add per clock) that starts a
// new calculation whenever N differs from the last value it captured.
// Optional macro SUMMATION_CLOSED_FORM_EN replaces the FSM with a one-clock
// closed-form N*(N+1)/2 datapath.
module summation #(
   parameter int unsigned N_WIDTH   = 4,
   parameter int unsigned SUM_WIDTH = 7
) (
   input  logic        clock,
   input  logic        reset,
   summation_if.slave  bus
);

   // Result must hold N_max*(N_max+1)/2 without wrapping
   if (SUM_WIDTH < 2 * N_WIDTH - 1) begin : g_width_check
      $error("summation: SUM_WIDTH too small for N_WIDTH");
   end

   logic [SUM_WIDTH-1:0] sum_reg;
   logic [SUM_WIDTH-1:0] sum_nxt;

   assign bus.sum = sum_reg;

`ifdef SUMMATION_CLOSED_FORM_EN

   localparam int unsigned PROD_WIDTH = 2 * N_WIDTH + 1;

   logic [PROD_WIDTH-1:0] n_ext;
   logic [PROD_WIDTH-1:0] product;
   logic [PROD_WIDTH-1:0] half;

   // Full-width N*(N+1)/2, truncated to the result width
   always_comb begin
      n_ext   = PROD_WIDTH'(bus.N);
      product = n_ext * (n_ext + PROD_WIDTH'(1));
      half    = product >> 1;
      sum_nxt = SUM_WIDTH'(half);
   end

   // Result register, tracks N every cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum_reg <= '0;
      end else begin
         sum_reg <= sum_nxt;
      end
   end

`else

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [N_WIDTH-1:0]   n_last;
   logic [N_WIDTH-1:0]   n_last_nxt;
   logic [N_WIDTH-1:0]   cnt;
   logic [N_WIDTH-1:0]   cnt_nxt;
   logic [SUM_WIDTH-1:0] acc;
   logic [SUM_WIDTH-1:0] acc_nxt;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath updates; sum only moves on the CALC exit edge
   always_comb begin
      state_nxt  = state;
      n_last_nxt = n_last;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      sum_nxt    = sum_reg;
      unique case (state)
         IDLE: begin
            if (bus.N != n_last) begin
               n_last_nxt = bus.N;
               cnt_nxt    = bus.N;
               acc_nxt    = '0;
               state_nxt  = CALC;
            end
         end
         CALC: begin
            if (cnt != '0) begin
               acc_nxt = acc + SUM_WIDTH'(cnt);
               cnt_nxt = cnt - N_WIDTH'(1);
            end else begin
               sum_nxt   = acc;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers; reset aborts any calculation in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         n_last  <= '0;
         cnt     <= '0;
         acc     <= '0;
         sum_reg <= '0;
      end else begin
         n_last  <= n_last_nxt;
         cnt     <= cnt_nxt;
         acc     <= acc_nxt;
         sum_reg <= sum_nxt;
      end
   end

`endif

endmodule

// File: tb/tb_summation.sv
// Testbench for summation: vector table plus hand sequences, with a scoreboard
// queue that every change of sum must match in order.
module tb_summation;

   localparam int unsigned N_WIDTH   = 4;
   localparam int unsigned SUM_WIDTH = 7;

   logic clock;
   logic reset;

   summation_if #(.N_WIDTH(N_WIDTH), .SUM_WIDTH(SUM_WIDTH)) bus ();

   summation #(.N_WIDTH(N_WIDTH), .SUM_WIDTH(SUM_WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [N_WIDTH-1:0]   n;
      logic [SUM_WIDTH-1:0] exp;
   } vec_t;

   vec_t                 vecs[9];
   logic [SUM_WIDTH-1:0] sb[$];
   logic [SUM_WIDTH-1:0] model_sum;
   int                   total;
   int                   bad;

   task automatic check(input string name, input logic [SUM_WIDTH-1:0] act,
                        input logic [SUM_WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: sum=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance k rising edges, then settle 1 time unit past the edge
   task automatic tick(input int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   // Drive N, queue the expected result, verify exact commit edge
   task automatic apply_n(input string name, input logic [N_WIDTH-1:0] n,
                          input logic [SUM_WIDTH-1:0] exp);
      int commit;
`ifdef SUMMATION_CLOSED_FORM_EN
      commit = 0;
`else
      commit = int'(n) + 1;
`endif
      bus.N = n;
      if (exp != model_sum) sb.push_back(exp);
      tick(commit);
      check({name, "_early"}, bus.sum, model_sum);
      tick(1);
      check(name, bus.sum, exp);
      model_sum = exp;
   endtask

   // Scoreboard: each observed change of sum must be the next queued value
   initial begin : monitor
      logic [SUM_WIDTH-1:0] prev;
      logic [SUM_WIDTH-1:0] exp;
      prev = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev = bus.sum;
         end else if (bus.sum !== prev) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: sum=%0d expected no change (prev=%0d) at %0t",
                        bus.sum, prev, $time);
            end else begin
               exp = sb.pop_front();
               check("sb_order", bus.sum, exp);
            end
            prev = bus.sum;
         end
      end
   end

   initial begin
      total     = 0;
      bad       = 0;
      model_sum = '0;

      vecs[0] = '{n: 4'd5,  exp: 7'd15};
      vecs[1] = '{n: 4'd15, exp: 7'd120};
      vecs[2] = '{n: 4'd1,  exp: 7'd1};
      vecs[3] = '{n: 4'd7,  exp: 7'd28};
      vecs[4] = '{n: 4'd0,  exp: 7'd0};
      vecs[5] = '{n: 4'd3,  exp: 7'd6};
      vecs[6] = '{n: 4'd9,  exp: 7'd45};
      vecs[7] = '{n: 4'd14, exp: 7'd105};
      vecs[8] = '{n: 4'd2,  exp: 7'd3};

      // Asynchronous reset with N=0, then idle with nothing to compute
      reset = 1'b1;
      bus.N = '0;
      #2 reset = 1'b0;
      #1 check("reset_async", bus.sum, 7'd0);
      tick(1);
      reset = 1'b1;
      tick(10);
      check("reset_idle", bus.sum, 7'd0);

      // Table of N values, each must commit at its exact latency
      for (int i = 0; i < 9; i++) begin
         apply_n($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].n, vecs[i].exp);
         if (i == 0) begin
            tick(20);
            check("hold_n5", bus.sum, 7'd15);
         end
      end

`ifndef SUMMATION_CLOSED_FORM_EN
      // N changes mid-calculation: stale result commits first, then the new one
      bus.N = 4'd10;
      sb.push_back(7'd55);
      tick(4);
      bus.N = 4'd3;
      sb.push_back(7'd6);
      tick(7);
      check("chg_early", bus.sum, 7'd3);
      tick(1);
      check("chg_first", bus.sum, 7'd55);
      tick(4);
      check("chg_hold", bus.sum, 7'd55);
      tick(1);
      check("chg_second", bus.sum, 7'd6);
      model_sum = 7'd6;

      // Reset mid-calculation aborts; N=12 is re-detected after release
      bus.N = 4'd12;
      sb.push_back(7'd78);
      tick(5);
      reset = 1'b0;
      #1 check("reset_mid", bus.sum, 7'd0);
      sb.delete();
      model_sum = '0;
      tick(1);
      reset = 1'b1;
      apply_n("reset_recover", 4'd12, 7'd78);
`else
      // Reset clears the one-clock result, which returns on the next edge
      apply_n("cf_n12", 4'd12, 7'd78);
      reset = 1'b0;
      #1 check("reset_mid", bus.sum, 7'd0);
      sb.delete();
      model_sum = '0;
      tick(1);
      reset = 1'b1;
      apply_n("reset_recover", 4'd12, 7'd78);
`endif

      tick(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
